// File: rtl/td4_pkg.sv
// td4_pkg: shared loader state encoding and program-memory constants.
package td4_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    localparam int TD4_DEPTH = 16;
    localparam logic [7:0] TD4_NOP = 8'h00;
endpackage

// File: rtl/td4_prog_ram.sv
// td4_prog_ram: program byte array with a synchronous write port and asynchronous read port.
module td4_prog_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/td4_prog_loader.sv
// td4_prog_loader: host-loadable TD4 program memory that holds the CPU until an image is loaded.
// Build with TD4_LOADER_CHECKSUM_EN to append and verify a trailing checksum byte.
module td4_prog_loader import td4_pkg::*; #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] NOP_BYTE = TD4_NOP
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    input  logic              LD_START,
    input  logic              LD_VALID,
    input  logic [DATA_W-1:0] LD_DATA,
    output logic              LD_READY,
    output logic              CPU_HOLD,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR
);
    localparam int DEPTH = 2**ADDR_W;
`ifdef TD4_LOADER_CHECKSUM_EN
    localparam int PW = ADDR_W + 1;
    localparam int LAST = DEPTH;
    localparam bit CS = 1'b1;
`else
    localparam int PW = ADDR_W;
    localparam int LAST = DEPTH - 1;
    localparam bit CS = 1'b0;
`endif

    state_t            state, state_n;
    logic [PW-1:0]     wptr;
    logic              hs, last, pass, we;
    logic [DATA_W-1:0] rdata;

    assign LD_READY  = state == LOAD;
    assign CPU_HOLD  = state != RUN;
    assign LOAD_DONE = state == RUN;
    // A byte arriving with LD_START is dropped even when already loading.
    assign hs   = LD_VALID && LD_READY && !LD_START;
    assign last = hs && wptr == PW'(LAST);
    assign we   = hs && !CLR && !(CS && last);
    assign D    = LOAD_DONE ? rdata : NOP_BYTE;

`ifdef TD4_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum, sum_n;
    logic              load_err;

    assign sum_n    = sum + LD_DATA;
    assign pass     = sum_n == '0;
    assign LOAD_ERR = load_err;

    always_ff @(posedge CLK)
        if (CLR || LD_START) begin
            sum      <= '0;
            load_err <= 1'b0;
        end else if (hs) begin
            sum <= sum_n;
            if (last) load_err <= !pass;
        end
`else
    assign pass     = 1'b1;
    assign LOAD_ERR = 1'b0;
`endif

    always_comb begin
        state_n = state;
        if (LD_START) state_n = LOAD;
        else if (last) state_n = pass ? RUN : IDLE;
    end

    always_ff @(posedge CLK)
        state <= CLR ? IDLE : state_n;

    always_ff @(posedge CLK)
        if (CLR || LD_START) wptr <= '0;
        else if (hs) wptr <= wptr + PW'(1);

    td4_prog_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk  (CLK),
        .we   (we),
        .waddr(wptr[ADDR_W-1:0]),
        .wdata(LD_DATA),
        .raddr(A),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_td4_prog_loader.sv
// tb_td4_prog_loader: scoreboard bench; accepted bytes are queued and compared against fetch reads.
module tb_td4_prog_loader;
    logic       CLK = 0, CLR = 0, LD_START = 0, LD_VALID = 0;
    logic [3:0] A = 0;
    logic [7:0] D, LD_DATA = 0;
    logic       LD_READY, CPU_HOLD, LOAD_DONE, LOAD_ERR;
    int         total = 0, bad = 0;
    logic [7:0] img [16];
    logic [7:0] exp_q [$];

    td4_prog_loader dut (
        .CLK(CLK), .CLR(CLR), .A(A), .D(D),
        .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA),
        .LD_READY(LD_READY), .CPU_HOLD(CPU_HOLD), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic start();
        @(negedge CLK);
        LD_START = 1;
        exp_q.delete();
        @(negedge CLK);
        LD_START = 0;
        total++;
        if (LD_READY !== 1'b1) begin bad++; $display("FAIL start_ready got=%b want=1", LD_READY); end
    endtask

    task automatic put(input logic [7:0] b, input bit store);
        LD_VALID = 1;
        LD_DATA  = b;
        if (store) exp_q.push_back(b);
        @(negedge CLK);
        LD_VALID = 0;
    endtask

    task automatic stream(input bit gaps);
        logic [7:0] s = 0;
        for (int i = 0; i < 16; i++) begin
`ifndef TD4_LOADER_CHECKSUM_EN
            if (i == 15) begin
                total++;
                if (CPU_HOLD !== 1'b1) begin bad++; $display("FAIL hold_before_last got=%b want=1", CPU_HOLD); end
            end
`endif
            put(img[i], 1);
            s += img[i];
            if (gaps) @(negedge CLK);
        end
`ifdef TD4_LOADER_CHECKSUM_EN
        total++;
        if (CPU_HOLD !== 1'b1) begin bad++; $display("FAIL hold_before_last got=%b want=1", CPU_HOLD); end
        put(8'h00 - s, 0);
`endif
        total++;
        if (CPU_HOLD !== 1'b0 || LOAD_DONE !== 1'b1)
            begin bad++; $display("FAIL release got hold=%b done=%b want 0/1", CPU_HOLD, LOAD_DONE); end
    endtask

    task automatic sweep(input string name);
        logic [7:0] e;
        for (int a = 0; a < 16; a++) begin
            A = 4'(a);
            #1;
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL %s empty scoreboard at A=%0d", name, a); end
            else begin
                e = exp_q.pop_front();
                if (D !== e) begin bad++; $display("FAIL %s A=%0d got=%h want=%h", name, a, D, e); end
            end
        end
    endtask

    task automatic test_reset();
        CLR = 1;
        repeat (2) @(negedge CLK);
        CLR = 0;
        for (int a = 0; a < 16; a++) begin
            A = 4'(a);
            #1;
            total++;
            if (D !== 8'h00 || CPU_HOLD !== 1 || LD_READY !== 0 || LOAD_DONE !== 0 || LOAD_ERR !== 0)
                begin bad++; $display("FAIL reset A=%0d got D=%h h=%b r=%b d=%b e=%b want 00/1/0/0/0", a, D, CPU_HOLD, LD_READY, LOAD_DONE, LOAD_ERR); end
        end
        LD_VALID = 1;
        LD_DATA  = 8'h77;
        repeat (2) @(negedge CLK);
        LD_VALID = 0;
        total++;
        if (LD_READY !== 0 || CPU_HOLD !== 1) begin bad++; $display("FAIL idle_valid got r=%b h=%b want 0/1", LD_READY, CPU_HOLD); end
    endtask

    task automatic test_load();
        img[0] = 8'hB5;
        for (int i = 1; i < 16; i++) img[i] = 8'(i);
        start();
        stream(0);
        sweep("load");
    endtask

    task automatic test_restart();
        start();
        for (int i = 0; i < 7; i++) begin
            put(8'hA0 + 8'(i), 1);
            if (i % 2 == 0) @(negedge CLK);
        end
        start();
        for (int i = 0; i < 16; i++) img[i] = 8'h40 ^ 8'(i * 7);
        stream(1);
        sweep("restart");
    endtask

    task automatic test_clr_midload();
        start();
        for (int i = 0; i < 9; i++) put(8'hC0 + 8'(i), 1);
        @(negedge CLK);
        CLR = 1;
        @(negedge CLK);
        CLR = 0;
        A = 0;
        #1;
        total++;
        if (D !== 8'h00 || LD_READY !== 0 || CPU_HOLD !== 1)
            begin bad++; $display("FAIL clr_mid got D=%h r=%b h=%b want 00/0/1", D, LD_READY, CPU_HOLD); end
        for (int i = 0; i < 16; i++) img[i] = 8'hF0 - 8'(i);
        start();
        stream(0);
        sweep("clr_reload");
    endtask

    task automatic test_start_with_byte();
        @(negedge CLK);
        LD_START = 1;
        LD_VALID = 1;
        LD_DATA  = 8'hEE;
        exp_q.delete();
        @(negedge CLK);
        LD_START = 0;
        LD_VALID = 0;
        A = 0;
        #1;
        total++;
        if (LD_READY !== 1 || CPU_HOLD !== 1 || LOAD_DONE !== 0 || D !== 8'h00)
            begin bad++; $display("FAIL start_byte got r=%b h=%b d=%b D=%h want 1/1/0/00", LD_READY, CPU_HOLD, LOAD_DONE, D); end
        for (int i = 0; i < 16; i++) img[i] = 8'h11 * 8'(i + 1);
        stream(0);
        sweep("start_byte");
    endtask

`ifdef TD4_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        start();
        for (int i = 0; i < 16; i++) put(8'h01, 1);
        put(8'hF0, 0);
        total++;
        if (CPU_HOLD !== 0 || LOAD_ERR !== 0) begin bad++; $display("FAIL cs_pass got h=%b e=%b want 0/0", CPU_HOLD, LOAD_ERR); end
        sweep("cs_pass");
        start();
        for (int i = 0; i < 16; i++) put(8'h01, 1);
        put(8'hF1, 0);
        repeat (3) begin
            total++;
            if (CPU_HOLD !== 1 || LOAD_ERR !== 1 || LD_READY !== 0 || D !== 8'h00)
                begin bad++; $display("FAIL cs_fail got h=%b e=%b r=%b D=%h want 1/1/0/00", CPU_HOLD, LOAD_ERR, LD_READY, D); end
            @(negedge CLK);
        end
        start();
        total++;
        if (LOAD_ERR !== 0) begin bad++; $display("FAIL cs_clear got=%b want=0", LOAD_ERR); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_restart();
        test_clr_midload();
        test_start_with_byte();
`ifdef TD4_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
